score_renderer: RTL
===================

Name: score_renderer

Overview:
- Draws a multi-digit decimal value (score, distance) as seven-segment glyphs on the VGA pixel stream.
- Successor to the single-digit combinational segment drawer. Adds parametrised digit count, integer pixel scaling, leading-zero blanking and an on-chip sequential binary-to-BCD converter.
- Adds a registered pixel output and a frame-safe digit update, so the displayed value never tears mid-frame.
- Sits between the game-state logic (score counter) and the pixel colour mux.

Parameters:
- DIGITS, 4: number of decimal digits drawn; range 1..6.
- BIN_W, 14: width of binary input value.
- SCALE, 1: pixel magnification of each glyph; allowed values 1, 2, 4.
- DIG_GAP, 2: blank screen pixels between adjacent digit cells.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- org_x  in  10  left column of the most-significant digit cell.
- org_y  in  10  top row of the digit cells.
- value  in  BIN_W  binary value to display.
- load  in  1  one-cycle request to convert and display value; normally pulsed at vsync.
- blank_lz  in  1  1 = blank leading zeros.
- busy  out  1  conversion in progress.
- is_seg  out  1  current pixel lies on a lit segment; registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy=0, is_seg=0.
  - Displayed digit registers all 0; pending flag cleared.
  - Any conversion in progress is aborted; no partial digits are committed.
- Capture and saturation:
  - load sampled high while idle captures value.
  - Values above 10^DIGITS-1 saturate to 10^DIGITS-1, so DIGITS=4 shows 9999.
- Converter FSM (states IDLE, SHIFT, COMMIT):
  - Shift-add-3 double-dabble, one bit per cycle.
  - load sampled at edge k gives busy=1 for edges k+1..k+BIN_W.
  - On edge k+BIN_W all DIGITS display registers update together and busy returns to 0.
- Load while busy:
  - The new value is stored in a one-deep pending register; a later load overwrites it.
  - On COMMIT with pending set, the FSM restarts immediately from the pending value (busy stays 1) and clears pending.
  - Load on the same edge as COMMIT counts as pending.
- Glyph cell geometry:
  - Each cell is 10x20 glyph units; one unit = SCALE x SCALE screen pixels.
  - Cell i (i=0 is most significant) starts at column org_x + i*(10*SCALE+DIG_GAP), row org_y.
  - Local unit coordinates: lx = (x - cell_x)/SCALE, ly = (y - org_y)/SCALE, computed by shift.
  - Subtractions use 11-bit signed arithmetic; a negative result means outside the cell.
- Segment rectangles in units (inclusive bounds):
  - a: ly 0-1, lx 2-7.
  - b: ly 2-8, lx 8-9.
  - c: ly 11-17, lx 8-9.
  - d: ly 18-19, lx 2-7.
  - e: ly 11-17, lx 0-1.
  - f: ly 2-8, lx 0-1.
  - g: ly 9-10, lx 2-7.
- Encoding: standard abcdefg, e.g. 0 = abcdef, 1 = bc, 8 = all segments.
- Leading-zero blanking: with blank_lz=1, digit i is blanked if it and all more-significant digits are 0. The least-significant digit is never blanked.
- Pixel path:
  - is_seg at edge n+1 reflects x,y at edge n; latency exactly 1.
  - Pixels in the gaps between cells, or outside all cells, give 0.
  - Pixel rendering is independent of the converter: digits shown are always the last committed set.

Decomposition:
- Shared package (seg_pkg) holds:
  - GLYPH_W=10 and GLYPH_H=20.
  - Segment rectangle bound constants.
  - A function mapping a 4-bit digit to the 7-bit abcdefg pattern.
- One sub-module: bin2bcd_seq.
  - Parametrised by BIN_W and DIGITS.
  - Interface: start/value in; done/bcd out; DIGITS*4 bits.
  - Owns the SHIFT loop; the parent owns saturation, pending and commit.

Test Plan:
- Reset with DIGITS=4, SCALE=1, DIG_GAP=2, org=(100,50), blank_lz=1:
  - pixel (138,50) -> is_seg=1 one cycle later (ones digit "0", segment a).
  - pixel (102,50) -> 0 (thousands digit blanked).
- load with value=1234 at edge k:
  - busy=1 for exactly 14 cycles, falls at edge k+14.
  - Afterwards pixel (108,55) -> 1 ('1' segment b); pixel (100,55) -> 0.
- value=12000 -> displays 9999:
  - pixel (104,59) -> 1 (g of '9').
  - pixel (100,65) -> 0 (e absent in '9').
- load 5 at k, load 7 at k+3, load 8 at k+6:
  - 5 commits at k+14.
  - busy stays high, then 8 commits at k+28; 7 never displayed.
- SCALE=2, value=8, org=(0,0), blank_lz=1:
  - ones cell starts at column 66.
  - pixel (66+4,18) -> 1 (g at unit (2,9)).
  - pixel (66+3,18) -> 0 (unit lx=1, ly=9 not lit).
- Reset asserted at k+5 of a conversion of 42:
  - busy=0 next edge; display remains all zeros.
  - The next load of 42 converts normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment score renderer.
// Holds glyph cell dimensions in glyph units, the segment rectangle
// bounds, the digit-to-abcdefg mapping and a unit-grid hit test.
package seg_pkg;

  localparam int GLYPH_W = 10;
  localparam int GLYPH_H = 20;

  // Column bands (inclusive, glyph units)
  localparam int HX0 = 2;   // horizontal bars a, g, d
  localparam int HX1 = 7;
  localparam int LX0 = 0;   // left verticals f, e
  localparam int LX1 = 1;
  localparam int RX0 = 8;   // right verticals b, c
  localparam int RX1 = 9;

  // Row bands (inclusive, glyph units)
  localparam int AY0 = 0;
  localparam int AY1 = 1;
  localparam int UY0 = 2;   // upper verticals b, f
  localparam int UY1 = 8;
  localparam int GY0 = 9;
  localparam int GY1 = 10;
  localparam int BY0 = 11;  // lower verticals c, e
  localparam int BY1 = 17;
  localparam int DY0 = 18;
  localparam int DY1 = 19;

  // Bit 6 = a ... bit 0 = g. Non-decimal codes draw nothing.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // True when unit (lx, ly) lies on a lit segment of pattern pat.
  function automatic logic seg_hit(input logic [6:0] pat, input int lx, input int ly);
    logic h_col, l_col, r_col;
    logic a_row, u_row, g_row, b_row, d_row;
    h_col = (lx >= HX0) && (lx <= HX1);
    l_col = (lx >= LX0) && (lx <= LX1);
    r_col = (lx >= RX0) && (lx <= RX1);
    a_row = (ly >= AY0) && (ly <= AY1);
    u_row = (ly >= UY0) && (ly <= UY1);
    g_row = (ly >= GY0) && (ly <= GY1);
    b_row = (ly >= BY0) && (ly <= BY1);
    d_row = (ly >= DY0) && (ly <= DY1);
    return (pat[6] && h_col && a_row) ||
           (pat[5] && r_col && u_row) ||
           (pat[4] && r_col && b_row) ||
           (pat[3] && h_col && d_row) ||
           (pat[2] && l_col && b_row) ||
           (pat[1] && l_col && u_row) ||
           (pat[0] && h_col && g_row);
  endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Pixel/value bus between the game logic (master) and score_renderer (slave).
//   x, y          current pixel
//   org_x, org_y  top-left of the most-significant digit cell
//   value, load   value to display and its one-cycle load request
//   blank_lz      leading-zero blanking enable
//   busy, is_seg  conversion in progress / registered pixel hit
interface score_renderer_if #(parameter int BIN_W = 14);
  logic [9:0]       x;
  logic [9:0]       y;
  logic [9:0]       org_x;
  logic [9:0]       org_y;
  logic [BIN_W-1:0] value;
  logic             load;
  logic             blank_lz;
  logic             busy;
  logic             is_seg;

  modport master (output x, y, org_x, org_y, value, load, blank_lz,
                  input  busy, is_seg);
  modport slave  (input  x, y, org_x, org_y, value, load, blank_lz,
                  output busy, is_seg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
//   clk, rst_n  pixel clock, synchronous active-low reset (aborts a run)
//   i_start     load i_value; the MSB is shifted in on this same edge
//   i_value     binary input (BIN_W >= 2)
//   o_done      high in the cycle whose closing edge shifts the last bit;
//               o_bcd is complete from the following cycle
//   o_bcd       DIGITS packed BCD digits, least significant in [3:0]
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_value,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    r_sr;
  logic [DIGITS*4-1:0] r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_active;

  function automatic logic [DIGITS*4-1:0] dabble(input logic [DIGITS*4-1:0] b,
                                                 input logic bit_in);
    logic [DIGITS*4-1:0] t;
    t = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[DIGITS*4-2:0], bit_in};
  endfunction

  // r_cnt counts bits still to shift after the current contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bcd    <= dabble('0, i_value[BIN_W-1]);
      r_sr     <= i_value << 1;
      r_cnt    <= CNT_W'(BIN_W - 1);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= dabble(r_bcd, r_sr[BIN_W-1]);
      r_sr  <= r_sr << 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_active <= 1'b0;
    end
  end

  assign o_done = r_active && (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_renderer.sv
// Multi-digit seven-segment score overlay for the VGA pixel stream.
//   clk, rst_n  pixel clock, synchronous active-low reset
//   bus         score_renderer_if slave: pixel position, origin, value/load,
//               blank_lz in; busy and registered is_seg out
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no conversion; waiting for load
// SHIFT  | converter shifting; loads go to the pending register
// COMMIT | BCD complete; copy to display, restart if a value is waiting
module score_renderer
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int SCALE   = 1,
  parameter int DIG_GAP = 2
) (
  input  logic clk,
  input  logic rst_n,
  score_renderer_if.slave bus
);

  localparam int MAX_VAL = 10**DIGITS - 1;
  localparam int PITCH   = GLYPH_W * SCALE + DIG_GAP;
  localparam int SH      = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]          r_state;
  logic                r_pend;
  logic [BIN_W-1:0]    r_pend_val;
  logic [DIGITS*4-1:0] r_digits;
  logic                r_is_seg;

  logic                w_start;
  logic [BIN_W-1:0]    w_start_val;
  logic                w_done;
  logic [DIGITS*4-1:0] w_bcd;

  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
    if (32'(v) > MAX_VAL) return BIN_W'(MAX_VAL);
    return v;
  endfunction

  // A load arriving on the COMMIT edge with nothing pending starts directly,
  // which is the same as parking it and restarting from it immediately.
  always_comb begin
    w_start     = 1'b0;
    w_start_val = sat(bus.value);
    case (r_state)
      S_IDLE:   w_start = bus.load;
      S_COMMIT: begin
        if (r_pend) begin
          w_start     = 1'b1;
          w_start_val = r_pend_val;
        end else begin
          w_start = bus.load;
        end
      end
      default:  w_start = 1'b0;
    endcase
  end

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_value (w_start_val),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_digits   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.load) r_state <= S_SHIFT;
        S_SHIFT: begin
          if (bus.load) begin
            r_pend     <= 1'b1;
            r_pend_val <= sat(bus.value);
          end
          if (w_done) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_digits <= w_bcd;
          r_state  <= (r_pend || bus.load) ? S_SHIFT : S_IDLE;
          // Only a load on top of an existing pending value stays pending.
          r_pend   <= r_pend && bus.load;
          if (bus.load) r_pend_val <= sat(bus.value);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);

  // Pixel path: 11-bit wrap-around subtraction, bit 10 set means left/above.
  logic [10:0] w_dy, w_dx, w_cell_x;
  int          w_lx, w_ly;
  logic        w_y_ok, w_zero_run, w_blank, w_hit;
  logic [3:0]  w_dig;

  always_comb begin
    w_dy       = {1'b0, bus.y} - {1'b0, bus.org_y};
    w_ly       = int'(w_dy >> SH);
    w_y_ok     = !w_dy[10] && (w_ly < GLYPH_H);
    w_hit      = 1'b0;
    w_zero_run = 1'b1;
    w_cell_x   = '0;
    w_dx       = '0;
    w_lx       = 0;
    w_dig      = '0;
    w_blank    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_cell_x   = {1'b0, bus.org_x} + 11'(i * PITCH);
      w_dx       = {1'b0, bus.x} - w_cell_x;
      w_lx       = int'(w_dx >> SH);
      w_dig      = r_digits[(DIGITS-1-i)*4 +: 4];
      w_zero_run = w_zero_run && (w_dig == 4'd0);
      w_blank    = bus.blank_lz && w_zero_run && (i != DIGITS - 1);
      if (!w_dx[10] && w_y_ok && (w_lx < GLYPH_W) && !w_blank &&
          seg_hit(seg_pattern(w_dig), w_lx, w_ly))
        w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_is_seg <= 1'b0;
    else        r_is_seg <= w_hit;
  end

  assign bus.is_seg = r_is_seg;

endmodule
